fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the program counter and instruction memory. Owns the PC and issues one outstanding imem request at a time over a req/ack handshake. Delivers fetched words to decode over a valid/ready interface. Holds fetch on control-flow opcodes (JAL, JALR, BRANCH) until execute resolves them, so no wrong-path instruction is ever fetched.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_perf_ctr.sv | 44 ++++
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and opcode helper for the fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_BR = 2'd2
    } fetch_state_e;

    // True for opcodes whose successor PC is only known after execute.
    function automatic logic is_ctrl_flow(input logic [OPC_W-1:0] op);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: three free-running, wrapping 32-bit fetch performance counters.
// Ports:
//   CLK, RESET            clock, synchronous active-high clear
//   consume_i             an instruction was handed to decode this cycle
//   wait_br_i             fetch is parked waiting for a control-flow resolution
//   imem_wait_i           a request is outstanding and not acked this cycle
//   perf_fetch_cnt_o      count of consume_i cycles
//   perf_br_stall_cnt_o   count of wait_br_i cycles
//   perf_imem_wait_cnt_o  count of imem_wait_i cycles
module fetch_perf_ctr
    import fetch_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            consume_i,
    input  logic            wait_br_i,
    input  logic            imem_wait_i,
    output logic [XLEN-1:0] perf_fetch_cnt_o,
    output logic [XLEN-1:0] perf_br_stall_cnt_o,
    output logic [XLEN-1:0] perf_imem_wait_cnt_o
);

    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] br_stall_cnt_q;
    logic [XLEN-1:0] imem_wait_cnt_q;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_cnt_q     <= '0;
            br_stall_cnt_q  <= '0;
            imem_wait_cnt_q <= '0;
        end else begin
            if (consume_i)   fetch_cnt_q     <= fetch_cnt_q + XLEN'(1);
            if (wait_br_i)   br_stall_cnt_q  <= br_stall_cnt_q + XLEN'(1);
            if (imem_wait_i) imem_wait_cnt_q <= imem_wait_cnt_q + XLEN'(1);
        end
    end

    assign perf_fetch_cnt_o     = fetch_cnt_q;
    assign perf_br_stall_cnt_o  = br_stall_cnt_q;
    assign perf_imem_wait_cnt_o = imem_wait_cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, keeps at most one imem
// request outstanding, hands fetched words to decode over valid/ready, and parks
// on JAL/JALR/BRANCH until execute resolves them so no wrong-path word is fetched.
// Optional macro FETCH_CTRL_PERF_EN adds perf_fetch_cnt, perf_br_stall_cnt and
// perf_imem_wait_cnt outputs.
// Ports:
//   CLK, RESET                    clock, synchronous active-high reset
//   imem_req/imem_addr            fetch request and address (current PC)
//   imem_ack/imem_rdata           fetch response
//   if_valid/if_instr/if_pc       held instruction toward decode
//   if_ready, hz_stall            decode accept and load-use stall
//   br_resolve/br_taken/br_target control-flow resolution from execute
//   wait_br                       fetch parked on an unresolved control-flow op
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready,
    input  logic            hz_stall,
    input  logic            br_resolve,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            wait_br
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_br_stall_cnt,
    output logic [XLEN-1:0] perf_imem_wait_cnt
`endif
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] ifpc_q;
    logic            valid_q;
    logic            wait_br_q;

    logic            consume;
    logic            slot_free;
    logic            fetch_fire;
    logic [XLEN-1:0] pc_inc;

    // Handshake qualifiers; a pending request cannot be withdrawn because the
    // slot can only fill through an ack.
    always_comb begin
        consume    = valid_q & if_ready & ~hz_stall;
        slot_free  = ~valid_q | consume;
        imem_req   = (state_q == S_REQ) & slot_free;
        fetch_fire = imem_req & imem_ack;
        pc_inc     = pc_q + XLEN'(4);
    end

    // Sequencer state, PC and the decode-facing instruction slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            ifpc_q    <= RESET_PC;
            valid_q   <= 1'b0;
            wait_br_q <= 1'b0;
        end else begin
            // A new word replaces the old one even if the old one drains this cycle.
            if (fetch_fire) begin
                instr_q <= imem_rdata;
                ifpc_q  <= pc_q;
                valid_q <= 1'b1;
            end else if (consume) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    // Any ack seen here belongs to a request abandoned by reset.
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (fetch_fire) begin
                        if (is_ctrl_flow(imem_rdata[OPC_W-1:0])) begin
                            state_q   <= S_WAIT_BR;
                            wait_br_q <= 1'b1;
                        end else begin
                            pc_q <= pc_inc;
                        end
                    end
                end
                S_WAIT_BR: begin
                    if (br_resolve) begin
                        pc_q      <= br_taken ? (br_target & ~XLEN'(3)) : pc_inc;
                        state_q   <= S_REQ;
                        wait_br_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    wait_br_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = ifpc_q;
    assign wait_br   = wait_br_q;

`ifdef FETCH_CTRL_PERF_EN
    fetch_perf_ctr u_perf (
        .CLK                  (CLK),
        .RESET                (RESET),
        .consume_i            (consume),
        .wait_br_i            (wait_br_q),
        .imem_wait_i          (imem_req & ~imem_ack),
        .perf_fetch_cnt_o     (perf_fetch_cnt),
        .perf_br_stall_cnt_o  (perf_br_stall_cnt),
        .perf_imem_wait_cnt_o (perf_imem_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios for fetch_ctrl with a per-cycle reference
// model plus hand-computed literal expectations at key points.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        hz_stall;
    logic        br_resolve;
    logic        br_taken;
    logic [31:0] br_target;
    logic        wait_br;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_br_stall_cnt;
    logic [31:0] perf_imem_wait_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .hz_stall   (hz_stall),
        .br_resolve (br_resolve),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .wait_br    (wait_br)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetch_cnt     (perf_fetch_cnt),
        .perf_br_stall_cnt  (perf_br_stall_cnt),
        .perf_imem_wait_cnt (perf_imem_wait_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_fresh: first cycle after reset; m_wait: parked on a control-flow word.
    bit          m_init = 1'b0;
    bit          m_fresh, m_wait, m_valid;
    logic [31:0] m_pc, m_instr, m_ifpc;
    bit          m_consume, m_req, m_fire;
    logic [6:0]  m_op;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] m_cnt_fetch, m_cnt_br, m_cnt_wait;
`endif

    // Compare on the falling edge (inputs stable), then advance the model to
    // what the next rising edge must produce.
    always @(negedge CLK) begin
        m_consume = m_valid & if_ready & ~hz_stall;
        m_req     = ~m_fresh & ~m_wait & (~m_valid | m_consume);
        m_fire    = m_req & imem_ack;
        if (m_init) begin
            chk("model imem_req",  {31'b0, imem_req}, {31'b0, m_req});
            chk("model imem_addr", imem_addr, m_pc);
            chk("model if_valid",  {31'b0, if_valid}, {31'b0, m_valid});
            chk("model if_instr",  if_instr, m_instr);
            chk("model if_pc",     if_pc, m_ifpc);
            chk("model wait_br",   {31'b0, wait_br}, {31'b0, m_wait});
`ifdef FETCH_CTRL_PERF_EN
            chk("model perf_fetch",  perf_fetch_cnt, m_cnt_fetch);
            chk("model perf_br",     perf_br_stall_cnt, m_cnt_br);
            chk("model perf_wait",   perf_imem_wait_cnt, m_cnt_wait);
`endif
        end
        if (RESET) begin
            m_init  = 1'b1;
            m_fresh = 1'b1;
            m_wait  = 1'b0;
            m_valid = 1'b0;
            m_pc    = RESET_PC;
            m_instr = NOP_INSTR;
            m_ifpc  = RESET_PC;
`ifdef FETCH_CTRL_PERF_EN
            m_cnt_fetch = 0;
            m_cnt_br    = 0;
            m_cnt_wait  = 0;
`endif
        end else if (m_init) begin
`ifdef FETCH_CTRL_PERF_EN
            if (m_consume)          m_cnt_fetch = m_cnt_fetch + 1;
            if (m_wait)             m_cnt_br    = m_cnt_br + 1;
            if (m_req && !imem_ack) m_cnt_wait  = m_cnt_wait + 1;
`endif
            if (m_fire) begin
                m_instr = imem_rdata;
                m_ifpc  = m_pc;
                m_valid = 1'b1;
            end else if (m_consume) begin
                m_valid = 1'b0;
            end
            if (m_fresh) begin
                m_fresh = 1'b0;
            end else if (m_wait) begin
                if (br_resolve) begin
                    m_pc   = br_taken ? {br_target[31:2], 2'b00} : m_pc + 32'd4;
                    m_wait = 1'b0;
                end
            end else if (m_fire) begin
                m_op = imem_rdata[6:0];
                if (m_op == 7'h6F || m_op == 7'h67 || m_op == 7'h63) m_wait = 1'b1;
                else m_pc = m_pc + 32'd4;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the DUT one cycle past S_IDLE, i.e. first request cycle for RESET_PC.
    task automatic do_reset();
        RESET = 1'b1; imem_ack = 1'b0; br_resolve = 1'b0; hz_stall = 1'b0;
        if_ready = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        RESET = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0000_0013; if_ready = 1'b1;
        hz_stall = 1'b0; br_resolve = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        tick(); tick();
        #1;
        chk("rst if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst if_instr", if_instr, 32'h0000_0013);
        chk("rst if_pc",    if_pc, 32'h0);
        chk("rst imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst wait_br",  {31'b0, wait_br}, 32'd0);
        chk("rst imem_addr", imem_addr, 32'h0);

        // 1: streaming fetch with combinational ack
        RESET = 1'b0; imem_ack = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("s1 imem_addr", imem_addr, 32'(4 * k));
            chk("s1 imem_req", {31'b0, imem_req}, 32'd1);
            if (k > 0) begin
                chk("s1 if_pc", if_pc, 32'(4 * (k - 1)));
                chk("s1 if_valid", {31'b0, if_valid}, 32'd1);
            end
            tick();
        end

        // 2: taken branch at pc 8, then JAL with unaligned target
        do_reset();
        imem_ack = 1'b1;
        #1 chk("s2 addr0", imem_addr, 32'h0);
        tick(); tick();
        imem_rdata = 32'h0000_0063;
        #1 chk("s2 addr8", imem_addr, 32'h8);
        tick();
        imem_rdata = 32'h0000_0013;
        #1;
        chk("s2 wait_br", {31'b0, wait_br}, 32'd1);
        chk("s2 req off", {31'b0, imem_req}, 32'd0);
        chk("s2 if_instr", if_instr, 32'h0000_0063);
        chk("s2 if_pc", if_pc, 32'h8);
        tick();
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        #1;
        chk("s2 wait_br2", {31'b0, wait_br}, 32'd1);
        chk("s2 req off2", {31'b0, imem_req}, 32'd0);
        tick();
        br_resolve = 1'b0; imem_rdata = 32'h0000_006F;
        #1;
        chk("s2 redirect", imem_addr, 32'h40);
        chk("s2 req on", {31'b0, imem_req}, 32'd1);
        chk("s2 wait_br off", {31'b0, wait_br}, 32'd0);
        tick();
        imem_rdata = 32'h0000_0013;
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h102;
        #1 chk("s2 jal wait", {31'b0, wait_br}, 32'd1);
        tick();
        br_resolve = 1'b0;
        #1 chk("s2 jal aligned", imem_addr, 32'h100);

        // 3: not-taken branch, then a stray resolve in S_REQ
        do_reset();
        imem_ack = 1'b1;
        tick(); tick();
        imem_rdata = 32'h0000_0063;
        tick();
        imem_rdata = 32'h0000_0013;
        tick();
        br_resolve = 1'b1; br_taken = 1'b0; br_target = 32'h40;
        tick();
        br_resolve = 1'b0;
        #1;
        chk("s3 not taken", imem_addr, 32'hC);
        chk("s3 req", {31'b0, imem_req}, 32'd1);
        imem_ack = 1'b0; br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h80;
        tick();
        br_resolve = 1'b0;
        #1;
        chk("s3 stray pc", imem_addr, 32'hC);
        chk("s3 stray wait", {31'b0, wait_br}, 32'd0);
        imem_ack = 1'b1;
        tick();
        #1 chk("s3 advance", imem_addr, 32'h10);

        // 4: load-use stall holds the slot and blocks requests
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h0010_0093;
        tick();
        imem_rdata = 32'h0020_0113; hz_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s4 hold pc", if_pc, 32'h0);
            chk("s4 hold instr", if_instr, 32'h0010_0093);
            chk("s4 hold valid", {31'b0, if_valid}, 32'd1);
            chk("s4 no req", {31'b0, imem_req}, 32'd0);
            tick();
        end
        hz_stall = 1'b0;
        #1;
        chk("s4 resume req", {31'b0, imem_req}, 32'd1);
        chk("s4 resume addr", imem_addr, 32'h4);
        tick();
        #1 chk("s4 next pc", if_pc, 32'h4);

        // 5: slow memory, ack three cycles late
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s5 req held", {31'b0, imem_req}, 32'd1);
            chk("s5 addr held", imem_addr, 32'h0);
            tick();
        end
        imem_ack = 1'b1;
        #1 chk("s5 addr at ack", imem_addr, 32'h0);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("s5 advanced", imem_addr, 32'h4);
        chk("s5 if_pc", if_pc, 32'h0);

        // 6: reset abandons a pending request; late ack in S_IDLE is dropped
        do_reset();
        imem_ack = 1'b1;
        tick(); tick();
        imem_ack = 1'b0;
        #1 chk("s6 pending", imem_addr, 32'h8);
        tick();
        RESET = 1'b1;
        tick();
        #1 chk("s6 req dropped", {31'b0, imem_req}, 32'd0);
        RESET = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0A13;
        tick();
        #1;
        chk("s6 late ack valid", {31'b0, if_valid}, 32'd0);
        chk("s6 late ack instr", if_instr, 32'h0000_0013);
        chk("s6 restart addr", imem_addr, 32'h0);
        chk("s6 restart req", {31'b0, imem_req}, 32'd1);
        tick();
        #1 chk("s6 first word", if_instr, 32'h0000_0A13);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
